// File: rtl/tap_timer.sv
// Tap-strobe driven down-counter timer with one-shot/periodic modes and a sticky irq.
// Optional overrun flag enabled by defining TAP_TIMER_OVERRUN_EN.
module tap_timer #(
    parameter int unsigned NTAPS  = 6,
    parameter int unsigned CWIDTH = 16,
    parameter int unsigned SWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NTAPS-1:0]  taps,
    input  logic [SWIDTH-1:0] cfg_tap_sel,
    input  logic [CWIDTH-1:0] cfg_period,
    input  logic              cfg_periodic,
    input  logic              start,
    input  logic              stop,
    input  logic              irq_ack,
    output logic [CWIDTH-1:0] count,
    output logic              busy,
    output logic              expired,
    output logic              irq,
    output logic              overrun
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [SWIDTH-1:0] sel_q;
    logic [CWIDTH-1:0] period_q;
    logic              periodic_q;

    logic strobe_c;
    logic start_ok_c;
    logic expire_c;

    // Strobe from the latched tap; out-of-range selects can never be latched.
    always_comb begin
        strobe_c = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            if (sel_q == SWIDTH'(i)) begin
                strobe_c = taps[i];
            end
        end
    end

    assign start_ok_c = start && (cfg_period != '0) && (32'(cfg_tap_sel) < NTAPS);

    // Priority: stop, then (re)start, then strobe-driven expiry.
    assign expire_c = (state == RUN) && strobe_c && (count == CWIDTH'(1))
                      && !stop && !start_ok_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            count      <= '0;
            expired    <= 1'b0;
            irq        <= 1'b0;
            sel_q      <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (stop) begin
                if (state == RUN) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            end else if (start_ok_c) begin
                sel_q      <= cfg_tap_sel;
                period_q   <= cfg_period;
                periodic_q <= cfg_periodic;
                count      <= cfg_period;
                state      <= RUN;
                busy       <= 1'b1;
            end else if (expire_c) begin
                expired <= 1'b1;
                if (periodic_q) begin
                    count <= period_q;
                end else begin
                    count <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if ((state == RUN) && strobe_c && (count != '0)) begin
                count <= count - CWIDTH'(1);
            end

            // An expiry in the same cycle as an ack wins, keeping irq set.
            if (expire_c) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef TAP_TIMER_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (irq_ack) begin
            overrun_q <= 1'b0;
        end else if (expire_c && irq) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tap_timer.sv
// Directed self-checking bench for tap_timer (default parameters).
// Overrun expectations follow TAP_TIMER_OVERRUN_EN.
module tb_tap_timer;

    localparam int unsigned NTAPS  = 6;
    localparam int unsigned CWIDTH = 16;
    localparam int unsigned SWIDTH = 3;
`ifdef TAP_TIMER_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NTAPS-1:0]  taps;
    logic [SWIDTH-1:0] cfg_tap_sel;
    logic [CWIDTH-1:0] cfg_period;
    logic              cfg_periodic;
    logic              start;
    logic              stop;
    logic              irq_ack;
    logic [CWIDTH-1:0] count;
    logic              busy;
    logic              expired;
    logic              irq;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;

    tap_timer #(.NTAPS(NTAPS), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .taps         (taps),
        .cfg_tap_sel  (cfg_tap_sel),
        .cfg_period   (cfg_period),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .irq_ack      (irq_ack),
        .count        (count),
        .busy         (busy),
        .expired      (expired),
        .irq          (irq),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int idx);
        taps[idx] = 1'b1;
        tick();
        taps = '0;
    endtask

    task automatic arm(input int sel, input int period, input logic periodic);
        cfg_tap_sel  = SWIDTH'(sel);
        cfg_period   = CWIDTH'(period);
        cfg_periodic = periodic;
        start        = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0; taps = '0; cfg_tap_sel = '0; cfg_period = '0;
        cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
        idle(2);
        check_eq("rst_count",   32'(count),   0);
        check_eq("rst_busy",    32'(busy),    0);
        check_eq("rst_expired", 32'(expired), 0);
        check_eq("rst_irq",     32'(irq),     0);
        check_eq("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        idle(1);

        // One-shot, period 3 on tap 0, strobe every 4 cycles
        arm(0, 3, 1'b0);
        check_eq("os_load",  32'(count), 3);
        check_eq("os_busy",  32'(busy),  1);
        strobe(0); check_eq("os_cnt1", 32'(count), 2); idle(3);
        strobe(0); check_eq("os_cnt2", 32'(count), 1); idle(3);
        strobe(0);
        check_eq("os_expired", 32'(expired), 1);
        check_eq("os_count0",  32'(count),   0);
        check_eq("os_idle",    32'(busy),    0);
        check_eq("os_irq",     32'(irq),     1);
        tick();
        check_eq("os_pulse_end", 32'(expired), 0);
        strobe(0);
        check_eq("os_no_wrap", 32'(count), 0);
        ack();
        check_eq("ack_irq", 32'(irq), 0);

        // Periodic, period 2 on tap 2; config inputs changed after start are ignored
        arm(2, 2, 1'b1);
        cfg_period = CWIDTH'(9); cfg_periodic = 1'b0; cfg_tap_sel = SWIDTH'(0);
        strobe(0);
        check_eq("per_wrong_tap", 32'(count), 2);
        for (int i = 1; i <= 6; i++) begin
            strobe(2);
            check_eq("per_expired", 32'(expired), (i % 2 == 0) ? 1 : 0);
            check_eq("per_count",   32'(count),   (i % 2 == 0) ? 2 : 1);
            check_eq("per_busy",    32'(busy),    1);
            tick();
        end
        check_eq("per_irq",     32'(irq),     1);
        check_eq("per_overrun", 32'(overrun), 32'(OVR));
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("stop_busy",  32'(busy),  0);
        check_eq("stop_count", 32'(count), 0);
        ack();
        check_eq("ack_ovr", 32'(overrun), 0);

        // Restart while running reloads without expiry
        arm(1, 4, 1'b0);
        strobe(1);
        check_eq("rs_dec", 32'(count), 3);
        arm(1, 2, 1'b0);
        check_eq("rs_count",   32'(count),   2);
        check_eq("rs_expired", 32'(expired), 0);
        stop = 1'b1; tick(); stop = 1'b0;

        // Illegal starts
        arm(0, 0, 1'b0);
        check_eq("ill_p0_busy",  32'(busy),  0);
        check_eq("ill_p0_count", 32'(count), 0);
        arm(7, 4, 1'b0);
        check_eq("ill_sel_busy",  32'(busy),  0);
        check_eq("ill_sel_count", 32'(count), 0);
        taps = '1; tick(); taps = '0;
        check_eq("ill_expired", 32'(expired), 0);
        check_eq("ill_irq",     32'(irq),     0);

        // Stop coincident with the final strobe
        arm(1, 1, 1'b0);
        taps[1] = 1'b1; stop = 1'b1; tick(); taps = '0; stop = 1'b0;
        check_eq("sx_expired", 32'(expired), 0);
        check_eq("sx_irq",     32'(irq),     0);
        check_eq("sx_count",   32'(count),   0);
        check_eq("sx_busy",    32'(busy),    0);

        // Overrun: two expiries without ack, then ack coincident with a third
        arm(0, 1, 1'b1);
        strobe(0);
        check_eq("ov1_irq", 32'(irq), 1);
        check_eq("ov1_ovr", 32'(overrun), 0);
        strobe(0);
        check_eq("ov2_irq", 32'(irq), 1);
        check_eq("ov2_ovr", 32'(overrun), 32'(OVR));
        taps[0] = 1'b1; irq_ack = 1'b1; tick(); taps = '0; irq_ack = 1'b0;
        check_eq("ov3_expired", 32'(expired), 1);
        check_eq("ov3_irq",     32'(irq),     1);
        check_eq("ov3_ovr",     32'(overrun), 0);
        stop = 1'b1; tick(); stop = 1'b0;

        // Reset mid-run after 2 strobes (irq still set from above)
        arm(3, 5, 1'b0);
        strobe(3); strobe(3);
        check_eq("rr_pre", 32'(count), 3);
        rst_n = 1'b0; taps[3] = 1'b1; tick(); taps = '0; rst_n = 1'b1;
        check_eq("rr_count",   32'(count),   0);
        check_eq("rr_busy",    32'(busy),    0);
        check_eq("rr_irq",     32'(irq),     0);
        check_eq("rr_expired", 32'(expired), 0);
        strobe(3); strobe(3); strobe(3);
        check_eq("rr_after_count", 32'(count),   0);
        check_eq("rr_after_exp",   32'(expired), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_timer.md
TAP_TIMER -- requirements
Module: tap_timer

Interface
REQ-001 SHALL have parameter NTAPS, default 6: width of the tap strobe input vector.
REQ-002 SHALL have parameter CWIDTH, default 16: width of the period and count registers.
REQ-003 SHALL have parameter SWIDTH, default 3: width of the tap select field, which is at least clog2(NTAPS).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port taps, input, NTAPS bits: single-cycle strobes from the upstream timebase.
REQ-007 SHALL have port cfg_tap_sel, input, SWIDTH bits: index of the tap used as the count strobe.
REQ-008 SHALL have port cfg_period, input, CWIDTH bits: number of strobes per expiry.
REQ-009 SHALL have port cfg_periodic, input, 1 bit: 1 = auto-reload after expiry, 0 = one-shot.
REQ-010 SHALL have port start, input, 1 bit: pulse that latches the config and arms the timer.
REQ-011 SHALL have port stop, input, 1 bit: pulse that aborts a running timer.
REQ-012 SHALL have port irq_ack, input, 1 bit: pulse that clears irq and overrun.
REQ-013 SHALL have port count, output, CWIDTH bits: strobes remaining until expiry.
REQ-014 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-015 SHALL have port expired, output, 1 bit: one-cycle pulse on each expiry.
REQ-016 SHALL have port irq, output, 1 bit: sticky expiry flag.
REQ-017 SHALL have port overrun, output, 1 bit: sticky flag meaning an expiry occurred while irq was already set.

Function
REQ-018 SHALL implement two states: IDLE and RUN; busy = (state == RUN).
REQ-019 SHALL latch cfg_tap_sel, cfg_period and cfg_periodic into internal registers on an accepted start; config inputs are ignored at all other times.
REQ-020 SHALL accept start only when cfg_period != 0 and cfg_tap_sel < NTAPS; an accepted start sets count = cfg_period and state = RUN on the same edge.
REQ-021 SHALL ignore a start that fails REQ-020, leaving state and count unchanged.
REQ-022 SHALL treat an accepted start while in RUN as a restart: re-latch the config and reload count; no expiry is generated.
REQ-023 SHALL give stop priority over start in the same cycle; stop in RUN sets state = IDLE and count = 0, and stop in IDLE has no effect.
REQ-024 SHALL, in RUN, take the strobe as taps[latched sel], sampled combinationally; a strobe with count > 1 decrements count by 1 on that edge.
REQ-025 SHALL, on a strobe with count == 1, register expired = 1 for exactly one cycle and set irq = 1.
REQ-026 SHALL, on that same edge, reload count = latched period and stay in RUN when periodic, or set count = 0 and state = IDLE when one-shot.
REQ-027 SHALL give stop priority over a coincident expiry: no expired pulse and no irq change.
REQ-028 SHALL have a latency of one edge from a tap strobe cycle to the updated count or expired pulse.
REQ-029 SHALL clear irq and overrun on irq_ack; when irq_ack coincides with an expiry, irq stays 1 and overrun stays 0.
REQ-030 SHALL keep strobes outside RUN from affecting the block; count never wraps below 0.

Reset
REQ-031 SHALL, when rst_n = 0 at a rising edge, force state = IDLE, count = 0, busy = 0, expired = 0, irq = 0, overrun = 0 and clear the latched config to 0.
REQ-032 SHALL let reset asserted mid-RUN abort the timer with no expired pulse; all other inputs are ignored while rst_n = 0.

Configuration
REQ-033 SHALL, with macro TAP_TIMER_OVERRUN_EN defined, set overrun when an expiry occurs with irq = 1 and no coincident irq_ack, with overrun sticky until irq_ack or reset.
REQ-034 SHALL, without TAP_TIMER_OVERRUN_EN, tie overrun to constant 0 and synthesize no overrun register; all other behaviour is identical.

Verification
REQ-035 SHALL cover one-shot: sel=0, period=3, periodic=0, start, taps[0] pulsed every 4 cycles -> count 3,2,1; expired one cycle after the 3rd strobe; count=0, busy=0, irq=1.
REQ-036 SHALL cover periodic: period=2, periodic=1, 6 strobes -> expired after strobes 2, 4 and 6; count reloads to 2; busy stays 1.
REQ-037 SHALL cover illegal start: period=0, or sel=7 with NTAPS=6 -> state stays IDLE, count=0, no pulses.
REQ-038 SHALL cover stop versus expiry: stop coincides with the strobe at count=1 -> no expired pulse, irq=0, count=0, busy=0.
REQ-039 SHALL cover overrun (macro on): two expiries with no ack -> irq=1, overrun=1; ack coincident with a 3rd expiry -> irq=1, overrun=0; with the macro off, overrun=0 throughout.
REQ-040 SHALL cover reset mid-run: period=5, rst_n=0 for 1 cycle after 2 strobes -> count=0, busy=0, irq=0; later strobes ignored.
